// File: rtl/scroll_pkg.sv
// Shared definitions for the hex scroller: FSM state encoding (also the
// leds[9:8] code), the blank segment pattern and the 0-F segment table.
// Segment bytes are active-low {dp,g,f,e,d,c,b,a}. The dp bit is always 1 (off).
package scroll_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SCROLL = 2'b01,
    HOLD   = 2'b10
  } state_t;

  localparam int NUM_DIGITS = 6;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Index 0 is the last entry in the concatenation.
  localparam logic [15:0][7:0] SEG_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };
endpackage

// File: rtl/seg7_decode.sv
// Combinational hex digit to 7-segment decoder.
//   digit : hex value 0-F
//   blank : force all segments off
//   seg   : active-low {dp,g,f,e,d,c,b,a}
module seg7_decode
  import scroll_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [7:0] seg
);
  assign seg = blank ? SEG_BLANK : SEG_TABLE[digit];
endmodule

// File: rtl/hex_scroll_ctrl.sv
// Scrolls a MSG_LEN-digit hex message across six 7-segment displays.
//   clk, rst      : clock and asynchronous active-high reset
//   switch[0]     : enable, switch[1]: direction (1 = right), switch[9:8]: speed
//   key[1:0]      : active-low buttons, [0] pause/resume and [1] restart
//   leds          : [7:0] one-hot pointer (0 in IDLE), [9:8] state code
//   hex0..hex5    : registered segment outputs, hex5 shows digit ptr
module hex_scroll_ctrl
  import scroll_pkg::*;
#(
  parameter int          TICK_DIV = 50_000_000,
  parameter int          MSG_LEN  = 8,
  parameter logic [31:0] MSG      = 32'h0000_0000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] switch,
  input  logic [1:0] key,
  output logic [9:0] leds,
  output logic [7:0] hex0,
  output logic [7:0] hex1,
  output logic [7:0] hex2,
  output logic [7:0] hex3,
  output logic [7:0] hex4,
  output logic [7:0] hex5
);
  localparam int CW = $clog2(TICK_DIV);
  localparam int PW = $clog2(MSG_LEN);
  localparam logic [31:0]     TDIV    = 32'(TICK_DIV);
  localparam logic [7:0][3:0] MSG_DIG = MSG;

  // Synchronizers. key_s3 is the edge-detect history. The pulse is
  // registered, so a pin fall reaches the FSM three edges later.
  logic [9:0] sw_s1, sw_s2;
  logic [1:0] key_s1, key_s2, key_s3, key_pls;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_s1   <= '0;
      sw_s2   <= '0;
      key_s1  <= 2'b11;
      key_s2  <= 2'b11;
      key_s3  <= 2'b11;
      key_pls <= '0;
    end else begin
      sw_s1   <= switch;
      sw_s2   <= sw_s1;
      key_s1  <= key;
      key_s2  <= key_s1;
      key_s3  <= key_s2;
      key_pls <= key_s3 & ~key_s2;
    end
  end

  state_t          state, state_n;
  logic [PW-1:0]   ptr, ptr_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [31:0]     period;
  logic            tick;
  logic [PW-1:0]   ptr_inc, ptr_dec;

  assign period  = TDIV >> sw_s2[9:8];
  // ">=" lets a shrinking period fire immediately.
  assign tick    = (state == SCROLL) && (32'(cnt) >= period - 32'd1);
  assign ptr_inc = (ptr == PW'(MSG_LEN - 1)) ? '0 : ptr + 1'b1;
  assign ptr_dec = (ptr == '0) ? PW'(MSG_LEN - 1) : ptr - 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      cnt   <= cnt_n;
    end
  end

  // Restart beats pause when both pulse together. HOLD freezes the counter,
  // so a resume continues the interrupted period.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    cnt_n   = cnt;
    if (!sw_s2[0]) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_n = SCROLL;
          ptr_n   = '0;
          cnt_n   = '0;
        end
        SCROLL, HOLD: begin
          if (key_pls[1]) begin
            state_n = SCROLL;
            ptr_n   = '0;
            cnt_n   = '0;
          end else if (key_pls[0]) begin
            state_n = (state == SCROLL) ? HOLD : SCROLL;
          end else if (state == SCROLL) begin
            if (tick) begin
              cnt_n = '0;
              ptr_n = sw_s2[1] ? ptr_dec : ptr_inc;
            end else begin
              cnt_n = cnt + 1'b1;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Display window. hexN shows digit (ptr + 5 - N) mod MSG_LEN.
  logic [NUM_DIGITS-1:0][3:0] win_dig;
  logic [NUM_DIGITS-1:0][7:0] seg_raw;
  logic [NUM_DIGITS-1:0][7:0] hex_q;
  logic [9:0]                 leds_q;
  logic                       idle;

  assign idle = (state == IDLE);

  for (genvar h = 0; h < NUM_DIGITS; h++) begin : g_win
    logic [3:0] sum, idx;
    assign sum        = 4'(ptr) + 4'(NUM_DIGITS - 1 - h);
    assign idx        = (sum >= 4'(MSG_LEN)) ? sum - 4'(MSG_LEN) : sum;
    assign win_dig[h] = MSG_DIG[idx[2:0]];
  end

  seg7_decode u_dec [NUM_DIGITS-1:0] (
    .digit (win_dig),
    .blank ({NUM_DIGITS{idle}}),
    .seg   (seg_raw)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hex_q  <= {NUM_DIGITS{SEG_BLANK}};
      leds_q <= '0;
    end else begin
      hex_q  <= seg_raw;
      leds_q <= idle ? 10'd0 : {state, 8'(8'd1 << ptr)};
    end
  end

  assign leds = leds_q;
  assign hex0 = hex_q[0];
  assign hex1 = hex_q[1];
  assign hex2 = hex_q[2];
  assign hex3 = hex_q[3];
  assign hex4 = hex_q[4];
  assign hex5 = hex_q[5];
endmodule
